trap_csr_unit: RTL
==================

# trap_csr_unit

Machine-mode CSR file and trap sequencer for the RV64 core. Sits at the execute/writeback boundary and consumes the main decoder's `exceptSignal`, `trapReturn` and `csrWriteEnable` outputs. Executes CSR instructions, takes synchronous exceptions and external/timer interrupts, and sequences `mret`. It supplies `privMode` back to the decoder and issues a one-cycle PC redirect with pipeline flush.

## Interface
- `MTVEC_RESET`, default 64'h0, reset value of mtvec (direct mode).
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous reset, active-high
- `instr_valid`  in  1  an instruction is at the commit point this cycle
- `pc`  in  64  PC of that instruction
- `instr`  in  32  raw instruction word (mtval on illegal)
- `exceptSignal`  in  3  from decoder: 001 ebreak, 010 ecall, 100 illegal, 000 none
- `trapReturn`  in  1  from decoder: mret
- `csrWriteEnable`  in  1  from decoder: CSR instruction
- `funct3`  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101/110/111 immediate forms
- `csr_addr`  in  12  funct12 field
- `rs1_idx`  in  5  rs1 index; zimm for immediate forms
- `rs1_data`  in  64  rs1 value
- `irq_ext`, `irq_timer`  in  1 each  level interrupt requests
- `csr_rdata`  out  64  old CSR value for rd writeback
- `trap_kill`  out  1  suppress regfile/memory writes of the current instruction
- `redirect_valid`  out  1  fetch must load `redirect_pc` and flush younger stages
- `redirect_pc`  out  64  trap vector or mepc
- `privMode`  out  2  current privilege: 00 U, 01 S, 11 M

## Operation
- Implemented CSRs: mstatus 0x300 (MIE[3], MPIE[7], MPP[12:11]; other bits read 0), mie 0x304 (MTIE[7], MEIE[11]), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (read-only: MTIP=irq_timer, MEIP=irq_ext).
- WARL: mepc[1:0] forced 0; mtvec[1] forced 0 (mode 00 direct, 01 vectored); MPP written as 10 stores 00.
- CSR ops: RW writes src; RS writes old|src; RC writes old&~src. src is rs1_data, or zero-extended rs1_idx for immediate forms. RS/RC with rs1_idx==0 perform no write.
- Illegal-CSR conditions, each raising an illegal trap (cause 2, mtval=instr): unimplemented address; csr_addr[9:8] > privMode; a write to csr_addr[11:10]==11; mret from privMode != 11.
- Exception causes: ebreak 3; ecall 8/9/11 for U/S/M. mtval is 0 except for illegal.
- Interrupts are taken when MIE=1 or privMode<11, gated by mie. External (cause 2^63|11) beats timer (2^63|7). Taken before the instruction: mepc=pc, and the instruction does not execute.
- Priority at commit: interrupt > illegal (decoder or CSR check) > ecall/ebreak > CSR write/mret.
- Trap entry: mepc←pc, mcause, mtval, MPIE←MIE, MIE←0, MPP←privMode, privMode←11.
- Vector: mtvec base for exceptions; base+4*cause[5:0] for interrupts in vectored mode.
- mret: MIE←MPIE, MPIE←1, privMode←MPP, MPP←00; target is mepc.
- FSM states RUN, TRAP, RET.
  - RUN: trap → TRAP; legal mret → RET.
  - TRAP / RET: each lasts one cycle, asserts the redirect, then returns to RUN. `instr_valid` is ignored in these states.

## Timing
- Reset: privMode=11, mstatus/mie/mscratch/mepc/mcause/mtval=0, mtvec=MTVEC_RESET, state RUN, redirect_valid=0, redirect_pc=0, trap_kill=0.
- `csr_rdata` and `trap_kill` are combinational in the commit cycle N. `csr_rdata` carries the pre-write value.
- CSR writes and trap state updates land on the rising edge ending cycle N.
- `redirect_valid` is high for exactly cycle N+1. `redirect_pc` is registered and stable during N+1.
- Back-to-back CSR instructions on consecutive cycles see each other's writes (read-after-write through the register, no bypass needed).
- Reset asserted mid-TRAP/RET aborts the redirect immediately; all outputs take their reset values asynchronously.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - mcycle 0xB00 increments every cycle; minstret 0xB02 increments on instr_valid & ~trap_kill.
  - Both are writable in M mode; a write in cycle N overrides that cycle's increment.
  - Read-only shadows cycle 0xC00 and instret 0xC02 are readable from any privilege.
- Undefined: all four addresses are unimplemented and raise illegal-CSR traps.

## Test plan
- After reset, csrrw x5, mscratch with rs1_data=0xDEAD → csr_rdata=0; next read returns 0xDEAD; no redirect.
- mtvec=0x1000; write mstatus MPP=00 and mepc=0x2004; mret → redirect_pc=0x2004 in N+1, privMode=00. Then ecall at pc 0x2004 → mcause=8, mepc=0x2004, redirect_pc=0x1000, privMode=11.
- In U mode, csrrs read of mstatus → illegal trap: mcause=2, mtval=instr, trap_kill=1 in N.
- mtvec=0x1001, MIE=1, MEIE=1, irq_ext and irq_timer both raised together with an ecall at pc 0x300 → mcause=2^63|11, mepc=0x300, redirect_pc=0x102C.
- csrrc mstatus with rs1_idx=0 → no write and no trap; csrrsi with zimm=8 → MIE set.
- With CSR_COUNTERS_EN: mcycle read 10 cycles apart differs by 10. Without it: reading 0xB00 traps with cause 2.

Source files
------------

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap sequencer (RUN/TRAP/RET) for the RV64 core.
// Optional feature: define CSR_COUNTERS_EN to add mcycle/minstret and cycle/instret.
module trap_csr_unit #(
    parameter logic [63:0] MTVEC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [63:0] pc,
    input  logic [31:0] instr,
    input  logic [2:0]  exceptSignal,
    input  logic        trapReturn,
    input  logic        csrWriteEnable,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_idx,
    input  logic [63:0] rs1_data,
    input  logic        irq_ext,
    input  logic        irq_timer,
    output logic [63:0] csr_rdata,
    output logic        trap_kill,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic [1:0]  privMode
);

    typedef enum logic [1:0] {RUN, TRAP, RET} state_e;

    state_e      state_q;
    logic        redirect_valid_q;
    logic [63:0] redirect_pc_q;

    logic [1:0]  priv_q, priv_d;
    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [1:0]  mst_mpp_q, mst_mpp_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mtval_q, mtval_d;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`endif

    logic        commit;
    logic        csr_impl;
    logic        does_write;
    logic        csr_ill;
    logic        ret_ill;
    logic        ext_p, tim_p;
    logic        take_irq;
    logic        exc_illegal;
    logic        take_trap;
    logic        do_mret;
    logic        csr_we;
    logic [63:0] src;
    logic [63:0] wdata;
    logic [63:0] trap_cause;
    logic [63:0] trap_val;
    logic [63:0] vec_base;
    logic [63:0] trap_vec;

    // CSR read mux; csr_rdata is the pre-write value in the commit cycle
    always_comb begin
        csr_rdata = 64'h0;
        csr_impl  = 1'b1;
        case (csr_addr)
            12'h300: csr_rdata = {51'h0, mst_mpp_q, 3'h0, mst_mpie_q,
                                  3'h0, mst_mie_q, 3'h0};
            12'h304: csr_rdata = {52'h0, mie_meie_q, 3'h0, mie_mtie_q, 7'h0};
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: csr_rdata = {52'h0, irq_ext, 3'h0, irq_timer, 7'h0};
`ifdef CSR_COUNTERS_EN
            12'hB00: csr_rdata = mcycle_q;
            12'hB02: csr_rdata = minstret_q;
            12'hC00: csr_rdata = mcycle_q;
            12'hC02: csr_rdata = minstret_q;
`endif
            default: csr_impl = 1'b0;
        endcase
    end

    // Commit-point decode: trap arbitration, CSR legality and write data
    always_comb begin
        commit     = instr_valid & (state_q == RUN);
        src        = funct3[2] ? {59'h0, rs1_idx} : rs1_data;
        does_write = (funct3[1:0] == 2'b01) |
                     ((funct3[1:0] != 2'b00) & (rs1_idx != 5'd0));
        unique case (funct3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = csr_rdata | src;
            2'b11:   wdata = csr_rdata & ~src;
            default: wdata = csr_rdata;
        endcase
        csr_ill = csrWriteEnable &
                  (~csr_impl | (csr_addr[9:8] > priv_q) |
                   ((csr_addr[11:10] == 2'b11) & does_write));
        ret_ill = trapReturn & (priv_q != 2'b11);
        ext_p   = irq_ext & mie_meie_q;
        tim_p   = irq_timer & mie_mtie_q;
        take_irq = commit & (mst_mie_q | (priv_q != 2'b11)) &
                   (ext_p | tim_p);
        exc_illegal = commit & (exceptSignal[2] | csr_ill | ret_ill);
        take_trap = take_irq | exc_illegal |
                    (commit & (exceptSignal[1] | exceptSignal[0]));
        do_mret = commit & trapReturn & ~take_trap;
        csr_we  = commit & csrWriteEnable & does_write & ~take_trap;

        trap_val = 64'h0;
        if (take_irq) begin
            trap_cause = ext_p ? {1'b1, 59'h0, 4'd11} : {1'b1, 59'h0, 4'd7};
        end else if (exc_illegal) begin
            trap_cause = 64'd2;
            trap_val   = {32'h0, instr};
        end else if (exceptSignal[1]) begin
            trap_cause = {60'h0, 2'b10, priv_q};
        end else begin
            trap_cause = 64'd3;
        end

        vec_base = {mtvec_q[63:2], 2'b00};
        trap_vec = (take_irq & mtvec_q[0]) ?
                   vec_base + {56'h0, trap_cause[5:0], 2'b00} : vec_base;
        trap_kill = ~reset & take_trap;
    end

    // Next-state for architectural CSR state: trap > mret > CSR write
    always_comb begin
        priv_d     = priv_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mst_mpp_d  = mst_mpp_q;
        mie_mtie_d = mie_mtie_q;
        mie_meie_d = mie_meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
`ifdef CSR_COUNTERS_EN
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'h0, commit & ~take_trap};
`endif
        if (take_trap) begin
            mepc_d     = {pc[63:2], 2'b00};
            mcause_d   = trap_cause;
            mtval_d    = trap_val;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            mst_mpp_d  = priv_q;
            priv_d     = 2'b11;
        end else if (do_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            priv_d     = mst_mpp_q;
            mst_mpp_d  = 2'b00;
        end else if (csr_we) begin
            case (csr_addr)
                12'h300: begin
                    mst_mie_d  = wdata[3];
                    mst_mpie_d = wdata[7];
                    mst_mpp_d  = (wdata[12:11] == 2'b10) ? 2'b00 : wdata[12:11];
                end
                12'h304: begin
                    mie_mtie_d = wdata[7];
                    mie_meie_d = wdata[11];
                end
                12'h305: mtvec_d    = {wdata[63:2], 1'b0, wdata[0]};
                12'h340: mscratch_d = wdata;
                12'h341: mepc_d     = {wdata[63:2], 2'b00};
                12'h342: mcause_d   = wdata;
                12'h343: mtval_d    = wdata;
`ifdef CSR_COUNTERS_EN
                12'hB00: mcycle_d   = wdata;
                12'hB02: minstret_d = wdata;
`endif
                default: ;
            endcase
        end
    end

    // Architectural CSR registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            priv_q     <= 2'b11;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mst_mpp_q  <= 2'b00;
            mie_mtie_q <= 1'b0;
            mie_meie_q <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 64'h0;
            mepc_q     <= 64'h0;
            mcause_q   <= 64'h0;
            mtval_q    <= 64'h0;
`ifdef CSR_COUNTERS_EN
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
`endif
        end else begin
            priv_q     <= priv_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mst_mpp_q  <= mst_mpp_d;
            mie_mtie_q <= mie_mtie_d;
            mie_meie_q <= mie_meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
`endif
        end
    end

    // Sequencer: one-cycle redirect after a trap or mret
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 64'h0;
        end else begin
            case (state_q)
                RUN: begin
                    if (take_trap) begin
                        state_q          <= TRAP;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= trap_vec;
                    end else if (do_mret) begin
                        state_q          <= RET;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= mepc_q;
                    end else begin
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= RUN;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign privMode       = priv_q;

endmodule
